// File: rtl/serial_cmd_pkg.sv
// serial_cmd_pkg: framing constants, decoder state encoding and marker lookup shared by the decoder
package serial_cmd_pkg;
   localparam logic [7:0] SOF_BYTE = 8'hFF;
   localparam logic [7:0] SPACE_BYTE = 8'h00;
   localparam logic [7:0] EOF_BYTE = 8'hEE;
   localparam int unsigned MAX_CMD_PAYLOAD_BYTES_DEF = 8;
   typedef enum logic [3:0] {
      S_IDLE, S_SOF1, S_SOF2, S_SPACE, S_LEN, S_PAYLOAD, S_EOF1, S_EOF2, S_DONE
   } dec_state_e;
   function automatic logic [7:0] marker_byte(input dec_state_e s);
      return (s == S_SPACE) ? SPACE_BYTE : (s == S_EOF1 || s == S_EOF2) ? EOF_BYTE : SOF_BYTE;
   endfunction
endpackage

// File: rtl/serial_cmd_decoder.sv
// serial_cmd_decoder: pops one FF FF 00 LEN payload EE EE frame from the RX FIFO and unpacks it into r0..r7
module serial_cmd_decoder
   import serial_cmd_pkg::*;
#(
   parameter int unsigned MAX_CMD_PAYLOAD_BYTES = MAX_CMD_PAYLOAD_BYTES_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_ready,
   input  logic [7:0] data,
   input  logic       cmd_processed_received,
   output logic       cmd_read_clk,
   output logic       cmd_processed,
   output logic [7:0] cmd_bytes_processed,
   output logic       cmd_decode_success,
   output logic [7:0] cmd_payload_r0,
   output logic [7:0] cmd_payload_r1,
   output logic [7:0] cmd_payload_r2,
   output logic [7:0] cmd_payload_r3,
   output logic [7:0] cmd_payload_r4,
   output logic [7:0] cmd_payload_r5,
   output logic [7:0] cmd_payload_r6,
   output logic [7:0] cmd_payload_r7
);
   localparam logic [7:0] MAX_LEN = 8'(MAX_CMD_PAYLOAD_BYTES);
   dec_state_e state_q, state_d, nxt;
   logic       phase_q, phase_d;
   logic       rd_q, rd_d;
   logic       ready_q;
   logic       proc_q, proc_d;
   logic       ok_q, ok_d;
   logic [7:0] cnt_q, cnt_d;
   logic [3:0] len_q, len_d;
   logic [3:0] idx_q, idx_d;
   logic [7:0] pay_q [8];
   logic [7:0] pay_d [8];
   logic       bad;
   // phase_q=1 is the pop cycle; the byte is judged at the end of the following cycle
   always_comb begin
      bad = (state_q == S_LEN) ? (data > MAX_LEN) :
            (state_q == S_PAYLOAD) ? 1'b0 : (data != marker_byte(state_q));
      case (state_q)
         S_SOF1:    nxt = S_SOF2;
         S_SOF2:    nxt = S_SPACE;
         S_SPACE:   nxt = S_LEN;
         S_LEN:     nxt = (data == 8'd0) ? S_EOF1 : S_PAYLOAD;
         S_PAYLOAD: nxt = (idx_q + 4'd1 == len_q) ? S_EOF1 : S_PAYLOAD;
         S_EOF1:    nxt = S_EOF2;
         default:   nxt = S_DONE;
      endcase
      state_d = state_q;
      phase_d = phase_q;
      rd_d = 1'b0;
      proc_d = proc_q;
      ok_d = ok_q;
      cnt_d = cnt_q;
      len_d = len_q;
      idx_d = idx_q;
      pay_d = pay_q;
      case (state_q)
         S_IDLE: if (cmd_ready && !ready_q) begin
            state_d = S_SOF1;
            rd_d = 1'b1;
            phase_d = 1'b1;
            cnt_d = 8'd1;
            ok_d = 1'b0;
            pay_d = '{default: 8'h00};
         end
         S_DONE: if (cmd_processed_received) begin
            proc_d = 1'b0;
            state_d = S_IDLE;
         end
         default: if (phase_q) phase_d = 1'b0;
         else if (bad) begin
            state_d = S_DONE;
            proc_d = 1'b1;
            ok_d = 1'b0;
            pay_d = '{default: 8'h00};
         end else begin
            if (state_q == S_LEN) begin
               len_d = data[3:0];
               idx_d = 4'd0;
            end
            if (state_q == S_PAYLOAD) begin
               pay_d[idx_q[2:0]] = data;
               idx_d = idx_q + 4'd1;
            end
            state_d = nxt;
            proc_d = (nxt == S_DONE);
            ok_d = (nxt == S_DONE);
            rd_d = (nxt != S_DONE);
            phase_d = (nxt != S_DONE);
            cnt_d = (nxt != S_DONE) ? cnt_q + 8'd1 : cnt_q;
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         phase_q <= 1'b0;
         rd_q <= 1'b0;
         ready_q <= 1'b0;
         proc_q <= 1'b0;
         ok_q <= 1'b0;
         cnt_q <= 8'd0;
         len_q <= 4'd0;
         idx_q <= 4'd0;
         pay_q <= '{default: 8'h00};
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         rd_q <= rd_d;
         ready_q <= cmd_ready;
         proc_q <= proc_d;
         ok_q <= ok_d;
         cnt_q <= cnt_d;
         len_q <= len_d;
         idx_q <= idx_d;
         pay_q <= pay_d;
      end
   end
   assign cmd_read_clk = rd_q;
   assign cmd_processed = proc_q;
   assign cmd_bytes_processed = cnt_q;
   assign cmd_decode_success = ok_q;
   assign cmd_payload_r0 = pay_q[0];
   assign cmd_payload_r1 = pay_q[1];
   assign cmd_payload_r2 = pay_q[2];
   assign cmd_payload_r3 = pay_q[3];
   assign cmd_payload_r4 = pay_q[4];
   assign cmd_payload_r5 = pay_q[5];
   assign cmd_payload_r6 = pay_q[6];
   assign cmd_payload_r7 = pay_q[7];
endmodule

// File: tb/tb_serial_cmd_decoder.sv
// tb_serial_cmd_decoder: 16-deep FIFO model feeding the decoder, directed frames checked by a scoreboard monitor
module tb_serial_cmd_decoder;
   typedef struct packed {
      logic        ok;
      logic [7:0]  n;
      logic [63:0] r;
   } exp_t;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cmd_ready = 1'b0;
   logic       ack = 1'b0;
   logic       push = 1'b0;
   logic       fclr = 1'b0;
   logic [7:0] din = 8'h00;
   logic [7:0] fifo_out = 8'h00;
   logic [7:0] mem [16];
   logic [4:0] wp = 5'd0;
   logic [4:0] rp = 5'd0;
   logic       cmd_read_clk, cmd_processed, cmd_decode_success;
   logic [7:0] cmd_bytes_processed;
   logic [7:0] r0, r1, r2, r3, r4, r5, r6, r7;
   int         checks = 0;
   int         errors = 0;
   exp_t       sb [$];
   exp_t       mon_e;
   bit         seen = 1'b0;
   logic [7:0] frame [$];

   always #5 clk = ~clk;

   serial_cmd_decoder dut (
      .clk(clk), .rst(rst), .cmd_ready(cmd_ready), .data(fifo_out),
      .cmd_processed_received(ack), .cmd_read_clk(cmd_read_clk),
      .cmd_processed(cmd_processed), .cmd_bytes_processed(cmd_bytes_processed),
      .cmd_decode_success(cmd_decode_success),
      .cmd_payload_r0(r0), .cmd_payload_r1(r1), .cmd_payload_r2(r2), .cmd_payload_r3(r3),
      .cmd_payload_r4(r4), .cmd_payload_r5(r5), .cmd_payload_r6(r6), .cmd_payload_r7(r7)
   );

   // registered-output FIFO: head byte updates on the pop edge, empty pops return stale memory
   always @(posedge clk) begin
      if (fclr) begin
         wp <= 5'd0;
         rp <= 5'd0;
      end else begin
         if (push) begin
            mem[wp[3:0]] <= din;
            wp <= wp + 5'd1;
         end
         if (cmd_read_clk) begin
            fifo_out <= mem[rp[3:0]];
            rp <= rp + 5'd1;
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (cmd_processed && !seen) begin
         if (sb.size() == 0) chk("unexpected_processed", 64'd1, 64'd0);
         else begin
            mon_e = sb.pop_front();
            chk("success", {63'd0, cmd_decode_success}, {63'd0, mon_e.ok});
            chk("bytes", {56'd0, cmd_bytes_processed}, {56'd0, mon_e.n});
            chk("r0", {56'd0, r0}, {56'd0, mon_e.r[7:0]});
            chk("r1", {56'd0, r1}, {56'd0, mon_e.r[15:8]});
            chk("r2", {56'd0, r2}, {56'd0, mon_e.r[23:16]});
            chk("r3", {56'd0, r3}, {56'd0, mon_e.r[31:24]});
            chk("r4", {56'd0, r4}, {56'd0, mon_e.r[39:32]});
            chk("r5", {56'd0, r5}, {56'd0, mon_e.r[47:40]});
            chk("r6", {56'd0, r6}, {56'd0, mon_e.r[55:48]});
            chk("r7", {56'd0, r7}, {56'd0, mon_e.r[63:56]});
         end
      end
      seen = cmd_processed;
   end

   task automatic load(input bit clr);
      if (clr) begin
         fclr = 1'b1;
         @(negedge clk);
         fclr = 1'b0;
      end
      for (int i = 0; i < frame.size(); i++) begin
         push = 1'b1;
         din = frame[i];
         @(negedge clk);
      end
      push = 1'b0;
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
   endtask

   task automatic run(input exp_t e, input bit clr);
      bit got = 1'b0;
      sb.push_back(e);
      load(clr);
      for (int i = 0; i < 300 && !got; i++) begin
         if (cmd_processed) got = 1'b1;
         else @(negedge clk);
      end
      chk("processed_timeout", {63'd0, got}, 64'd1);
      if (got) begin
         ack = 1'b1;
         @(negedge clk);
         ack = 1'b0;
         chk("ack_clears_processed", {63'd0, cmd_processed}, 64'd0);
         chk("bytes_held_after_ack", {56'd0, cmd_bytes_processed}, {56'd0, e.n});
      end
      @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_processed", {63'd0, cmd_processed}, 64'd0);
      chk("rst_bytes", {56'd0, cmd_bytes_processed}, 64'd0);
      chk("rst_read_clk", {63'd0, cmd_read_clk}, 64'd0);
      chk("rst_payload", {r7, r6, r5, r4, r3, r2, r1, r0}, 64'd0);
      rst = 1'b1;
      @(negedge clk);
      frame = '{8'hFF, 8'hFF, 8'h00, 8'h06, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'hEE, 8'hEE};
      run('{ok: 1'b1, n: 8'd12, r: 64'h0000_6655_4433_2211}, 1'b1);
      frame = '{8'h00, 8'hFF, 8'h00, 8'h01, 8'hAA, 8'hEE, 8'hEE};
      run('{ok: 1'b0, n: 8'd1, r: 64'd0}, 1'b1);
      frame = '{8'hFF, 8'hFF, 8'h55, 8'h01, 8'hAA, 8'hEE, 8'hEE};
      run('{ok: 1'b0, n: 8'd3, r: 64'd0}, 1'b1);
      frame = '{8'hFF, 8'hFF, 8'h00, 8'h09};
      for (int i = 1; i <= 9; i++) frame.push_back(8'(i));
      frame.push_back(8'hEE);
      frame.push_back(8'hEE);
      run('{ok: 1'b0, n: 8'd4, r: 64'd0}, 1'b1);
      frame = '{8'hFF, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h22, 8'hEE, 8'h00};
      run('{ok: 1'b0, n: 8'd8, r: 64'd0}, 1'b1);
      frame = '{8'hFF, 8'hFF, 8'h00, 8'h06, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'hEE, 8'hEE};
      run('{ok: 1'b1, n: 8'd12, r: 64'h0000_6655_4433_2211}, 1'b1);
      frame = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'hEE, 8'hEE};
      run('{ok: 1'b1, n: 8'd6, r: 64'd0}, 1'b0);
      frame = '{8'hFF, 8'hFF, 8'h00, 8'h06, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'hEE, 8'hEE};
      load(1'b1);
      repeat (6) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk("midrst_processed", {63'd0, cmd_processed}, 64'd0);
      chk("midrst_bytes", {56'd0, cmd_bytes_processed}, 64'd0);
      chk("midrst_success", {63'd0, cmd_decode_success}, 64'd0);
      chk("midrst_payload", {r7, r6, r5, r4, r3, r2, r1, r0}, 64'd0);
      repeat (40) @(negedge clk);
      chk("midrst_idle_no_pop", {63'd0, cmd_read_clk}, 64'd0);
      frame = '{8'hFF, 8'hFF, 8'h00, 8'h08};
      for (int i = 1; i <= 8; i++) frame.push_back(8'(i));
      frame.push_back(8'hEE);
      frame.push_back(8'hEE);
      run('{ok: 1'b1, n: 8'd14, r: 64'h0807_0605_0403_0201}, 1'b1);
      chk("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
